// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM symbol deframer.
package qam_pkg;

    typedef logic [1:0] sym_t;
    typedef logic [7:0] byte_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hF30A;

endpackage

// File: rtl/qam_byte_fifo.sv
// Synchronous byte FIFO with a registered head output and a sticky drop flag.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module qam_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       head_q, head_d;
    logic             ovf_q, ovf_d;
    logic             full, pop, push;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign rd_data  = head_q;
    assign overflow = ovf_q;

    always_comb begin
        pop    = rd_en && !empty;
        push   = wr_en && (!full || pop);
        rd_d   = rd_q + PTR_W'(pop);
        wr_d   = wr_q + PTR_W'(push);
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d  = ovf_q || (wr_en && !push);
        head_d = head_q;
        // a lone entry after this cycle is the byte being written now
        if (push && cnt_d == CNT_W'(1)) begin
            head_d = wr_data;
        end else if (cnt_d != '0) begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/qam_symbol_deframer.sv
// Majority-vote symbol slicer, sync hunter and MSB-first byte packer feeding a small FIFO.
// Optional macro DEFRAMER_INV_SYNC_EN: also lock on ~SYNC_WORD and invert that frame's payload.
//
//   state  | meaning
//   HUNT   | shifting symbols in, comparing against the sync word
//   LOCKED | packing 4 symbols per byte until FRAME_BYTES bytes are pushed
module qam_symbol_deframer
    import qam_pkg::*;
#(
    parameter int          SAMPLES_PER_SYM = 16,
    parameter logic [15:0] SYNC_WORD       = SYNC_WORD_DEFAULT,
    parameter int          FRAME_BYTES     = 32,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] data_demod,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic       locked,
    output logic       overflow
);

    localparam int SAMP_W = $clog2(SAMPLES_PER_SYM);
    localparam int VOTE_W = $clog2(SAMPLES_PER_SYM + 1);
    localparam int FCNT_W = $clog2(FRAME_BYTES + 1);
    localparam logic [VOTE_W-1:0] HALF = VOTE_W'(SAMPLES_PER_SYM / 2);

    logic [SAMP_W-1:0] samp_q, samp_d;
    logic [VOTE_W-1:0] vote_i_q, vote_i_d, vote_q_q, vote_q_d;
    logic [VOTE_W-1:0] vote_i_sum, vote_q_sum;
    logic              sym_stb_q, sym_stb_d;
    sym_t              sym_q, sym_d;

    state_t            state_q, state_d;
    logic [15:0]       shift_q, shift_d, shift_nxt;
    logic [1:0]        nsym_q, nsym_d;
    logic [5:0]        acc_q, acc_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    sym_t              pay_sym;
    logic              push;
    byte_t             push_byte;
    logic              fifo_empty;
`ifdef DEFRAMER_INV_SYNC_EN
    logic              inv_q, inv_d;
`endif

    always_comb begin
        vote_i_sum = vote_i_q + VOTE_W'(data_demod[1]);
        vote_q_sum = vote_q_q + VOTE_W'(data_demod[0]);
        samp_d     = samp_q + SAMP_W'(1);
        vote_i_d   = vote_i_sum;
        vote_q_d   = vote_q_sum;
        sym_stb_d  = 1'b0;
        sym_d      = sym_q;
        if (samp_q == SAMP_W'(SAMPLES_PER_SYM - 1)) begin
            samp_d    = '0;
            vote_i_d  = '0;
            vote_q_d  = '0;
            sym_stb_d = 1'b1;
            sym_d     = {vote_i_sum > HALF, vote_q_sum > HALF};
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        nsym_d    = nsym_q;
        acc_d     = acc_q;
        fcnt_d    = fcnt_q;
        push      = 1'b0;
        push_byte = '0;
        shift_nxt = {shift_q[13:0], sym_q};
`ifdef DEFRAMER_INV_SYNC_EN
        inv_d     = inv_q;
        pay_sym   = sym_q ^ {2{inv_q}};
`else
        pay_sym   = sym_q;
`endif
        case (state_q)
            HUNT: begin
                if (sym_stb_q) begin
                    shift_d = shift_nxt;
                    if (shift_nxt == SYNC_WORD) begin
                        state_d = LOCKED;
                        nsym_d  = '0;
                        fcnt_d  = '0;
                        acc_d   = '0;
                    end
`ifdef DEFRAMER_INV_SYNC_EN
                    else if (shift_nxt == ~SYNC_WORD) begin
                        state_d = LOCKED;
                        nsym_d  = '0;
                        fcnt_d  = '0;
                        acc_d   = '0;
                        inv_d   = 1'b1;
                    end
`endif
                end
            end
            LOCKED: begin
                if (sym_stb_q) begin
                    if (nsym_q == 2'd3) begin
                        push      = 1'b1;
                        push_byte = {acc_q, pay_sym};
                        nsym_d    = '0;
                        fcnt_d    = fcnt_q + FCNT_W'(1);
                        // dropped bytes still count towards the frame length
                        if (fcnt_q == FCNT_W'(FRAME_BYTES - 1)) begin
                            state_d = HUNT;
                            shift_d = '0;
`ifdef DEFRAMER_INV_SYNC_EN
                            inv_d   = 1'b0;
`endif
                        end
                    end else begin
                        acc_d  = {acc_q[3:0], pay_sym};
                        nsym_d = nsym_q + 2'd1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q    <= '0;
            vote_i_q  <= '0;
            vote_q_q  <= '0;
            sym_stb_q <= 1'b0;
            sym_q     <= '0;
            state_q   <= HUNT;
            shift_q   <= '0;
            nsym_q    <= '0;
            acc_q     <= '0;
            fcnt_q    <= '0;
`ifdef DEFRAMER_INV_SYNC_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            samp_q    <= samp_d;
            vote_i_q  <= vote_i_d;
            vote_q_q  <= vote_q_d;
            sym_stb_q <= sym_stb_d;
            sym_q     <= sym_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            nsym_q    <= nsym_d;
            acc_q     <= acc_d;
            fcnt_q    <= fcnt_d;
`ifdef DEFRAMER_INV_SYNC_EN
            inv_q     <= inv_d;
`endif
        end
    end

    qam_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push),
        .wr_data  (push_byte),
        .rd_en    (out_ready),
        .rd_data  (out_byte),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign out_valid = !fifo_empty;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_qam_symbol_deframer.sv
// Directed + randomized bench for qam_symbol_deframer with a queue-based reference model.
module tb_qam_symbol_deframer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] data_demod;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       locked;
    logic       overflow;

    always #5 clk = ~clk;

    qam_symbol_deframer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_demod (data_demod),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .locked     (locked),
        .overflow   (overflow)
    );

    localparam int SPS    = 16;
    localparam int FBYTES = 32;
    localparam int FDEPTH = 4;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [15:0] sync_w = 16'hF30A;
    bit          m_locked;
    logic [15:0] m_shift;
    int          m_nsym, m_frame;
    logic [7:0]  m_acc;
    bit          m_inv;
    bit          m_ovf;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx[$];
    bit          push_pend;
    logic [7:0]  push_val;
    bit          pend_v;
    logic [1:0]  pend_sym;
    int          idx, vi, vq;
    bit          rand_rdy;
    logic        rdy_level;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_locked = 0; m_shift = '0; m_nsym = 0; m_frame = 0; m_acc = '0;
        m_inv = 0; m_ovf = 0; exp_q.delete(); push_pend = 0; pend_v = 0;
        idx = 0; vi = 0; vq = 0;
    endtask

    task automatic model_sym(input logic [1:0] s);
        logic [1:0] p;
        if (!m_locked) begin
            m_shift = {m_shift[13:0], s};
            if (m_shift == sync_w) begin
                m_locked = 1; m_nsym = 0; m_frame = 0;
            end
`ifdef DEFRAMER_INV_SYNC_EN
            else if (m_shift == ~sync_w) begin
                m_locked = 1; m_nsym = 0; m_frame = 0; m_inv = 1;
            end
`endif
        end else begin
            p = m_inv ? ~s : s;
            m_acc = {m_acc[5:0], p};
            m_nsym++;
            if (m_nsym == 4) begin
                push_pend = 1;
                push_val  = m_acc;
                m_nsym    = 0;
                m_frame++;
                if (m_frame == FBYTES) begin
                    m_locked = 0; m_shift = '0; m_inv = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic [1:0] d);
        data_demod = d;
        out_ready  = rand_rdy ? 1'($urandom_range(1, 0)) : rdy_level;
        if (pend_v) begin
            pend_v = 0;
            model_sym(pend_sym);
        end
        if (exp_q.size() != 0 && out_ready) begin
            rx.push_back(out_byte);
            void'(exp_q.pop_front());
        end
        if (push_pend) begin
            push_pend = 0;
            if (exp_q.size() < FDEPTH) exp_q.push_back(push_val);
            else m_ovf = 1;
        end
        vi += int'(d[1]);
        vq += int'(d[0]);
        idx++;
        if (idx == SPS) begin
            pend_sym = {vi > SPS / 2, vq > SPS / 2};
            pend_v = 1; idx = 0; vi = 0; vq = 0;
        end
        @(posedge clk); #1;
        check("locked", 32'(locked), 32'(m_locked));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_q.size() != 0) check("out_byte", 32'(out_byte), 32'(exp_q[0]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; data_demod = 2'b00; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic send_sym(input logic [1:0] s);
        repeat (SPS) tick(s);
    endtask

    task automatic make_mask(input int k, output logic [15:0] m);
        int r;
        logic t;
        m = '0;
        for (int j = 0; j < k; j++) m[j] = 1'b1;
        for (int j = 15; j > 0; j--) begin
            r = $urandom_range(j, 0);
            t = m[j]; m[j] = m[r]; m[r] = t;
        end
    endtask

    task automatic send_votes(input int ki, input int kq);
        logic [15:0] mi, mq;
        make_mask(ki, mi);
        make_mask(kq, mq);
        for (int j = 0; j < SPS; j++) tick({mi[j], mq[j]});
    endtask

    task automatic send_noisy(input logic [1:0] s);
        int ki, kq;
        ki = s[1] ? $urandom_range(16, 9) : $urandom_range(8, 0);
        kq = s[0] ? $urandom_range(16, 9) : $urandom_range(8, 0);
        send_votes(ki, kq);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit noisy);
        for (int i = 3; i >= 0; i--) begin
            if (noisy) send_noisy(b[2*i+1 -: 2]);
            else send_sym(b[2*i+1 -: 2]);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 7; i >= 0; i--) send_sym(w[2*i+1 -: 2]);
    endtask

    initial begin
        logic [15:0] inv_w;
        rand_rdy = 0; rdy_level = 1'b1;
        rst_n = 1'b0; data_demod = 2'b00; out_ready = 1'b1;
        model_clear();
        do_reset();

        // constant 11 never matches the sync word
        repeat (20) send_sym(2'b11);
        check("hunt_locked", 32'(locked), 32'd0);
        check("hunt_valid", 32'(out_valid), 32'd0);

        // directed frame with vote-boundary symbols (9->1, 8->0)
        rx.delete();
        send_word(sync_w);
        send_byte(8'h1B, 0);
        send_byte(8'hE4, 0);
        send_votes(9, 8);
        send_votes(8, 9);
        send_votes(16, 0);
        send_votes(0, 8);
        repeat (FBYTES - 3) send_byte(8'($urandom), 1);
        repeat (3) send_sym(2'b00);
        check("frameA_count", 32'(rx.size()), 32'd32);
        if (rx.size() >= 3) begin
            check("frameA_byte0", 32'(rx[0]), 32'h1B);
            check("frameA_byte1", 32'(rx[1]), 32'hE4);
            check("frameA_votes", 32'(rx[2]), 32'h98);
        end

        // consumer stalled for a whole frame
        rx.delete();
        rdy_level = 1'b0;
        send_word(sync_w);
        repeat (FBYTES) send_byte(8'($urandom), 0);
        repeat (2) send_sym(2'b00);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_unlocked", 32'(locked), 32'd0);
        rdy_level = 1'b1;
        repeat (20) tick(2'b00);
        check("ovf_drained", 32'(rx.size()), 32'd4);

        // random backpressure with noisy symbols
        rx.delete();
        rand_rdy = 1;
        send_word(sync_w);
        repeat (FBYTES) send_byte(8'($urandom), 1);
        repeat (4) send_sym(2'b00);
        rand_rdy = 0;
        repeat (20) tick(2'b00);
        check("randrdy_count", 32'(rx.size()), 32'd32);

        // reset in the middle of a frame, then relock
        send_word(sync_w);
        repeat (5) send_byte(8'($urandom), 0);
        repeat (7) tick(2'b10);
        do_reset();
        rx.delete();
        send_word(sync_w);
        repeat (FBYTES) send_byte(8'($urandom), 1);
        repeat (3) send_sym(2'b00);
        check("relock_count", 32'(rx.size()), 32'd32);
        check("relock_ovf", 32'(overflow), 32'd0);

        // inverted sync word
        rx.delete();
        inv_w = ~sync_w;
        send_word(inv_w);
        send_byte(8'hE4, 0);
        repeat (FBYTES - 1) send_byte(8'h00, 0);
        repeat (3) send_sym(2'b00);
`ifdef DEFRAMER_INV_SYNC_EN
        check("inv_count", 32'(rx.size()), 32'd32);
        if (rx.size() != 0) check("inv_byte0", 32'(rx[0]), 32'h1B);
`else
        check("inv_nolock", 32'(rx.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
